flow_ctrl_fsm: RTL and testbench
================================

FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 5, number of monitored FIFOs (legal 1..32).
REQ-002 SHALL have parameter U_MFS, default 4, width of the main-FIFO threshold.
REQ-003 SHALL have parameter U_VCS, default 4, width of the VC-FIFO threshold.
REQ-004 SHALL have parameter U_DS, default 4, width of the D-FIFO threshold.
REQ-005 SHALL have parameter IDLE_HOLD, default 4, consecutive all-empty cycles required to leave ACTIVE (legal 1..255).
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port init  input  1  configuration-done strobe.
REQ-009 SHALL have ports umbral_MFs / umbral_VCs / umbral_Ds  input  U_MFS / U_VCS / U_DS  threshold values to capture.
REQ-010 SHALL have port FIFO_empties  input  NUM_FIFOS  per-FIFO empty flags, 1 = empty.
REQ-011 SHALL have port FIFO_errors  input  NUM_FIFOS  per-FIFO error flags, 1 = error.
REQ-012 SHALL have port error_clr  input  1  software request to leave ERROR.
REQ-013 SHALL have port present_state  output  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-014 SHALL have ports idle_out / active_out / error_out  output  1 each  registered state flags.
REQ-015 SHALL have port error_src  output  NUM_FIFOS  sticky mask of FIFOs that raised errors.
REQ-016 SHALL have ports umbral_MFs_out / umbral_VCs_out / umbral_Ds_out  output  U_MFS / U_VCS / U_DS  captured thresholds.
REQ-017 SHALL have port err_count  output  8  count of ERROR entries.

Function
REQ-018 All outputs SHALL be registered; inputs sampled at edge N are reflected in outputs after edge N (one-cycle latency).
REQ-019 idle_out, active_out, error_out SHALL equal 1 exactly when present_state is IDLE, ACTIVE, ERROR respectively; at most one SHALL be 1.
REQ-020 RESET SHALL go to INIT on the first edge with reset low.
REQ-021 INIT SHALL load all three threshold outputs from their inputs on every edge, including the exit edge.
REQ-022 INIT SHALL go to IDLE when init=1; otherwise it SHALL stay in INIT.
REQ-023 IDLE SHALL go to ERROR if any FIFO_errors bit is 1, else to ACTIVE if any FIFO_empties bit is 0, else stay.
REQ-024 ACTIVE SHALL go to ERROR if any FIFO_errors bit is 1 (priority over all else).
REQ-025 ACTIVE SHALL keep an 8-bit hold counter: it increments while FIFO_empties is all ones and clears to 0 on any zero bit.
REQ-026 ACTIVE SHALL go to IDLE on the edge where FIFO_empties is all ones and the hold counter equals IDLE_HOLD-1; the counter SHALL clear on that exit.
REQ-027 On ERROR entry, error_src SHALL load the FIFO_errors value that caused entry.
REQ-028 While in ERROR, error_src SHALL OR in FIFO_errors every cycle.
REQ-029 ERROR SHALL go to INIT only when error_clr=1 and FIFO_errors is all zeros; error_src SHALL clear on that edge.
REQ-030 init SHALL be ignored outside INIT; error_clr SHALL be ignored outside ERROR.
REQ-031 Unused encodings 5..7 SHALL go to RESET on the next edge.

Reset
REQ-032 Asserting reset SHALL immediately force, without waiting for clk: present_state=RESET, all flags 0, error_src 0, thresholds 0, hold counter 0, err_count 0.
REQ-033 Asserting reset in any state mid-operation SHALL abandon the state; the block SHALL restart through RESET->INIT.

Configuration
REQ-034 With macro FLOW_CTRL_ERR_CNT_EN defined, err_count SHALL increment by 1 on every ERROR entry and saturate at 255.
REQ-035 Without FLOW_CTRL_ERR_CNT_EN, err_count SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-036 Reset released, init=1 on 3rd cycle, umbral_MFs=4'hA -> states 0,1,1,2; umbral_MFs_out=4'hA; idle_out=1.
REQ-037 In IDLE, FIFO_empties=5'b11101 for 1 cycle, then 5'b11111 with IDLE_HOLD=4 -> ACTIVE next cycle; back to IDLE exactly 4 cycles after empties return to all ones.
REQ-038 In ACTIVE, FIFO_errors=5'b00100 for 1 cycle, then 5'b10000 for 1 cycle -> ERROR, error_src=5'b10100, error_out=1, err_count=1 (macro on) / 0 (macro off).
REQ-039 In ERROR, error_clr=1 while FIFO_errors=5'b00001 -> stays ERROR; errors cleared with error_clr=1 -> INIT, error_src=0.
REQ-040 Reset pulsed between clock edges while in ACTIVE -> present_state=0 and active_out=0 before the next rising edge.
REQ-041 Macro on, 256 error/clear cycles -> err_count holds at 255.

Source files
------------

// File: rtl/flow_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// flow_ctrl_fsm
//
// Purpose:
//   Flow-control supervisor for a bank of NUM_FIFOS FIFOs. After reset it waits
//   in INIT, capturing the threshold inputs, until software strobes init. It
//   then moves between IDLE and ACTIVE according to the FIFO empty flags.
//   The move back to IDLE is delayed until every FIFO has been empty for
//   IDLE_HOLD consecutive cycles. Any FIFO error sends it to ERROR, where the
//   offending FIFOs are accumulated in error_src until software clears it.
//
// Optional feature:
//   FLOW_CTRL_ERR_CNT_EN -- when defined, err_count counts ERROR entries and
//   saturates at 255. When undefined, err_count is constant 0.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-high reset
//   init             in   configuration-done strobe (only honoured in INIT)
//   umbral_MFs       in   [U_MFS] main-FIFO threshold to capture
//   umbral_VCs       in   [U_VCS] VC-FIFO threshold to capture
//   umbral_Ds        in   [U_DS]  D-FIFO threshold to capture
//   FIFO_empties     in   [NUM_FIFOS] per-FIFO empty flags (1 = empty)
//   FIFO_errors      in   [NUM_FIFOS] per-FIFO error flags (1 = error)
//   error_clr        in   request to leave ERROR (only honoured in ERROR)
//   present_state    out  [3] RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//   idle_out         out  registered IDLE flag
//   active_out       out  registered ACTIVE flag
//   error_out        out  registered ERROR flag
//   error_src        out  [NUM_FIFOS] sticky mask of FIFOs that raised errors
//   umbral_*_out     out  captured thresholds
//   err_count        out  [8] number of ERROR entries (saturating)
// -----------------------------------------------------------------------------
module flow_ctrl_fsm #(
  parameter int NUM_FIFOS = 5,
  parameter int U_MFS     = 4,
  parameter int U_VCS     = 4,
  parameter int U_DS      = 4,
  parameter int IDLE_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [U_MFS-1:0]     umbral_MFs,
  input  logic [U_VCS-1:0]     umbral_VCs,
  input  logic [U_DS-1:0]      umbral_Ds,
  input  logic [NUM_FIFOS-1:0] FIFO_empties,
  input  logic [NUM_FIFOS-1:0] FIFO_errors,
  input  logic                 error_clr,
  output logic [2:0]           present_state,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] error_src,
  output logic [U_MFS-1:0]     umbral_MFs_out,
  output logic [U_VCS-1:0]     umbral_VCs_out,
  output logic [U_DS-1:0]      umbral_Ds_out,
  output logic [7:0]           err_count
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Counter value on which the final all-empty cycle lands.
  localparam logic [7:0] HOLD_LAST = 8'(IDLE_HOLD - 1);

  state_t               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic [NUM_FIFOS-1:0] src_q, src_d;
  logic [U_MFS-1:0]     mf_q, mf_d;
  logic [U_VCS-1:0]     vc_q, vc_d;
  logic [U_DS-1:0]      ds_q, ds_d;
  logic                 idle_q, active_q, error_q;

  logic any_err;
  logic all_empty;

  assign any_err   = |FIFO_errors;
  assign all_empty = &FIFO_empties;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    src_d   = src_q;
    mf_d    = mf_q;
    vc_d    = vc_q;
    ds_d    = ds_q;

    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end

      ST_INIT: begin
        // Thresholds track the inputs for as long as we sit here, exit edge included.
        mf_d = umbral_MFs;
        vc_d = umbral_VCs;
        ds_d = umbral_Ds;
        if (init) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (any_err) begin
          state_d = ST_ERROR;
          src_d   = FIFO_errors;
        end else if (!all_empty) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (any_err) begin
          state_d = ST_ERROR;
          src_d   = FIFO_errors;
          hold_d  = 8'd0;
        end else if (all_empty) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          hold_d = 8'd0;
        end
      end

      ST_ERROR: begin
        // Leaving requires the error condition to have actually gone away.
        if (error_clr && !any_err) begin
          state_d = ST_INIT;
          src_d   = '0;
        end else begin
          src_d = src_q | FIFO_errors;
        end
      end

      default: begin
        state_d = ST_RESET;
        hold_d  = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RESET;
      hold_q   <= 8'd0;
      src_q    <= '0;
      mf_q     <= '0;
      vc_q     <= '0;
      ds_q     <= '0;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      src_q    <= src_d;
      mf_q     <= mf_d;
      vc_q     <= vc_d;
      ds_q     <= ds_d;
      // Flags are decoded from the next state so they line up with present_state.
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

`ifdef FLOW_CTRL_ERR_CNT_EN
  logic [7:0] err_count_q;
  logic       err_entry;

  assign err_entry = (state_d == ST_ERROR) && (state_q != ST_ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (err_entry && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign present_state  = state_q;
  assign idle_out       = idle_q;
  assign active_out     = active_q;
  assign error_out      = error_q;
  assign error_src      = src_q;
  assign umbral_MFs_out = mf_q;
  assign umbral_VCs_out = vc_q;
  assign umbral_Ds_out  = ds_q;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_flow_ctrl_fsm
//
// Directed-vector bench for flow_ctrl_fsm with default parameters
// (NUM_FIFOS=5, IDLE_HOLD=4). Expected values are written out by hand.
// Expected err_count follows FLOW_CTRL_ERR_CNT_EN as seen by this file.
// -----------------------------------------------------------------------------
module tb_flow_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umbral_MFs, umbral_VCs, umbral_Ds;
  logic [4:0] FIFO_empties, FIFO_errors;
  logic       error_clr;
  logic [2:0] present_state;
  logic       idle_out, active_out, error_out;
  logic [4:0] error_src;
  logic [3:0] umbral_MFs_out, umbral_VCs_out, umbral_Ds_out;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_entries = 0;

  flow_ctrl_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_MFs     (umbral_MFs),
    .umbral_VCs     (umbral_VCs),
    .umbral_Ds      (umbral_Ds),
    .FIFO_empties   (FIFO_empties),
    .FIFO_errors    (FIFO_errors),
    .error_clr      (error_clr),
    .present_state  (present_state),
    .idle_out       (idle_out),
    .active_out     (active_out),
    .error_out      (error_out),
    .error_src      (error_src),
    .umbral_MFs_out (umbral_MFs_out),
    .umbral_VCs_out (umbral_VCs_out),
    .umbral_Ds_out  (umbral_Ds_out),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef FLOW_CTRL_ERR_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return (n < 0) ? 8'd1 : 8'd0;
`endif
  endfunction

  // Checks present_state together with the three one-hot flags.
  task automatic check_state(input string tag, input logic [2:0] st);
    check({tag, "_state"}, present_state, st);
    check({tag, "_flags"}, {idle_out, active_out, error_out},
          {st == 3'd2, st == 3'd3, st == 3'd4});
  endtask

  initial begin
    reset        = 1'b1;
    init         = 1'b0;
    umbral_MFs   = 4'hA;
    umbral_VCs   = 4'h5;
    umbral_Ds    = 4'h3;
    FIFO_empties = 5'b11111;
    FIFO_errors  = 5'b00000;
    error_clr    = 1'b0;

    // Reset state
    #2;
    check_state("rst", 3'd0);
    check("rst_src", error_src, 5'd0);
    check("rst_thr", {umbral_MFs_out, umbral_VCs_out, umbral_Ds_out}, 12'h000);
    check("rst_cnt", err_count, 8'd0);

    // Release reset, init on the 3rd cycle: states 0,1,1,2
    reset = 1'b0;
    tick();
    check_state("boot1", 3'd1);
    tick();
    check_state("boot2", 3'd1);
    check("thr_init", {umbral_MFs_out, umbral_VCs_out, umbral_Ds_out}, 12'hA53);
    init = 1'b1;
    tick();
    check_state("boot3", 3'd2);
    check("mf_out", umbral_MFs_out, 4'hA);

    // init ignored in IDLE; thresholds frozen outside INIT; error_clr ignored
    umbral_MFs = 4'h1;
    error_clr  = 1'b1;
    tick();
    check_state("idle_hold", 3'd2);
    check("thr_frozen", umbral_MFs_out, 4'hA);
    init      = 1'b0;
    error_clr = 1'b0;

    // IDLE -> ACTIVE, then back to IDLE exactly 4 edges after all-empty
    FIFO_empties = 5'b11101;
    tick();
    check_state("to_active", 3'd3);
    FIFO_empties = 5'b11111;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_state($sformatf("hold%0d", i), 3'd3);
    end
    tick();
    check_state("back_idle", 3'd2);

    // Hold counter clears on a non-empty cycle
    FIFO_empties = 5'b01111;
    tick();
    check_state("act2", 3'd3);
    FIFO_empties = 5'b11111;
    tick();
    tick();
    FIFO_empties = 5'b11110;
    tick();
    FIFO_empties = 5'b11111;
    tick();
    tick();
    tick();
    check_state("hold_clr", 3'd3);
    tick();
    check_state("hold_clr_idle", 3'd2);

    // ACTIVE -> ERROR, error_src accumulates
    FIFO_empties = 5'b11110;
    tick();
    check_state("act3", 3'd3);
    FIFO_errors = 5'b00100;
    tick();
    exp_entries++;
    check_state("to_err", 3'd4);
    check("src_entry", error_src, 5'b00100);
    FIFO_errors = 5'b10000;
    tick();
    check_state("err_stay", 3'd4);
    check("src_or", error_src, 5'b10100);
    check("cnt1", err_count, exp_cnt(exp_entries));

    // error_clr with an error still present is refused
    FIFO_errors = 5'b00001;
    error_clr   = 1'b1;
    init        = 1'b1;
    tick();
    check_state("clr_refused", 3'd4);
    check("src_or2", error_src, 5'b10101);
    FIFO_errors = 5'b00000;
    init        = 1'b0;
    tick();
    check_state("clr_ok", 3'd1);
    check("src_cleared", error_src, 5'd0);
    error_clr = 1'b0;
    init      = 1'b1;
    tick();
    check_state("reinit", 3'd2);

    // IDLE -> ERROR directly
    init        = 1'b0;
    FIFO_errors = 5'b01000;
    tick();
    exp_entries++;
    check_state("idle_err", 3'd4);
    check("src_idle", error_src, 5'b01000);
    check("cnt2", err_count, exp_cnt(exp_entries));
    FIFO_errors = 5'b00000;
    error_clr   = 1'b1;
    tick();
    error_clr = 1'b0;
    init      = 1'b1;
    tick();
    init = 1'b0;

    // Asynchronous reset between edges while ACTIVE
    FIFO_empties = 5'b00000;
    tick();
    check_state("act4", 3'd3);
    #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", 3'd0);
    check("async_cnt", err_count, 8'd0);
    exp_entries = 0;
    #1;
    reset = 1'b0;
    tick();
    check_state("restart", 3'd1);
    init = 1'b1;
    tick();
    init = 1'b0;

    // 256 error/clear rounds: counter saturates
    for (int r = 0; r < 256; r++) begin
      FIFO_errors = 5'b00010;
      tick();
      exp_entries++;
      FIFO_errors = 5'b00000;
      error_clr   = 1'b1;
      tick();
      error_clr = 1'b0;
      init      = 1'b1;
      tick();
      init = 1'b0;
    end
    check_state("sat_idle", 3'd2);
    check("cnt_sat", err_count, exp_cnt(exp_entries));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
